// File: rtl/wb_pkg.sv
// Shared writeback parameters: default port/register-file sizing and the
// hard-wired zero register index used by writeback, register file and decode.
package wb_pkg;

    localparam int NREQ_DEF      = 3;
    localparam int REG_BITS_DEF  = 5;
    localparam int REG_WIDTH_DEF = 32;
    localparam int REG_ZERO      = 0;

    // Width of an index into n items; never collapses to zero bits.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches last+1, last+2, ... (mod N) and
// grants the first active request. The pointer register belongs to the caller.
module rr_arbiter
    import wb_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0]           req,
    input  logic [idx_bits(N)-1:0] last,
    output logic [N-1:0]           grant
);

    localparam int LW = idx_bits(N);

    logic [LW-1:0] idx;
    logic          found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = LW'((int'(last) + k) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/writeback_scheduler.sv
// Round-robin sharing of the register file write port among execution units,
// plus the per-register in-flight (busy) scoreboard queried by decode.
module writeback_scheduler
    import wb_pkg::*;
#(
    parameter int NREQ      = NREQ_DEF,
    parameter int REG_BITS  = REG_BITS_DEF,
    parameter int REG_WIDTH = REG_WIDTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [NREQ*REG_BITS-1:0]    req_dest,
    input  logic [NREQ*REG_WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]             req_ready,
    output logic                        write,
    output logic [REG_BITS-1:0]         wdest,
    output logic [REG_WIDTH-1:0]        wdata,
    input  logic                        alloc_valid,
    input  logic [REG_BITS-1:0]         alloc_dest,
    input  logic [REG_BITS-1:0]         q1,
    input  logic [REG_BITS-1:0]         q2,
    output logic                        q1_busy,
    output logic                        q2_busy,
    output logic [2**REG_BITS-1:0]      busy
);

    localparam int LW    = idx_bits(NREQ);
    localparam int NREGS = 2**REG_BITS;
    localparam logic [REG_BITS-1:0] ZERO_IDX = REG_BITS'(REG_ZERO);

    logic [NREQ-1:0]      grant;
    logic                 xfer;
    logic [LW-1:0]        sel_idx;
    logic [REG_BITS-1:0]  sel_dest;
    logic [REG_WIDTH-1:0] sel_data;

    logic [LW-1:0]        last_q, last_d;
    logic                 write_q, write_d;
    logic [REG_BITS-1:0]  wdest_q, wdest_d;
    logic [REG_WIDTH-1:0] wdata_q, wdata_d;
    logic [NREGS-1:0]     busy_q, busy_d;

    rr_arbiter #(.N(NREQ)) u_arb (
        .req   (req_valid),
        .last  (last_q),
        .grant (grant)
    );

    // No handshake may complete while reset is held.
    assign req_ready = rst ? '0 : grant;
    assign xfer      = |grant;

    always_comb begin
        sel_idx  = '0;
        sel_dest = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_idx  = LW'(i);
                sel_dest = req_dest[i*REG_BITS +: REG_BITS];
                sel_data = req_data[i*REG_WIDTH +: REG_WIDTH];
            end
        end
    end

    always_comb begin
        last_d  = last_q;
        write_d = 1'b0;
        wdest_d = wdest_q;
        wdata_d = wdata_q;
        if (xfer) begin
            last_d  = sel_idx;
            write_d = (sel_dest != ZERO_IDX);
            wdest_d = sel_dest;
            wdata_d = sel_data;
        end
    end

    // A same-cycle alloc beats the clear: it belongs to a newer producer.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_busy
            if (gi == REG_ZERO) begin : g_zero
                assign busy_d[gi] = 1'b0;
            end else begin : g_reg
                assign busy_d[gi] =
                    (alloc_valid && alloc_dest == REG_BITS'(gi)) ? 1'b1 :
                    (write_q && wdest_q == REG_BITS'(gi))        ? 1'b0 :
                    busy_q[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q  <= LW'(NREQ - 1);
            write_q <= 1'b0;
            wdest_q <= '0;
            wdata_q <= '0;
            busy_q  <= '0;
        end else begin
            last_q  <= last_d;
            write_q <= write_d;
            wdest_q <= wdest_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
        end
    end

    assign write   = write_q;
    assign wdest   = wdest_q;
    assign wdata   = wdata_q;
    assign busy    = busy_q;
    assign q1_busy = busy_q[q1];
    assign q2_busy = busy_q[q2];

endmodule
